// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default widths for the ALU arbiter slice.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: one-hot grant plus winner index.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the grant with its own idle state.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        grant  = 2'b00;
        winner = 1'b0;
        if (valid == 2'b11) begin
            // Contention goes to whichever port did not win last time.
            winner = ~last_grant;
            grant  = last_grant ? 2'b01 : 2'b10;
        end else if (valid[0]) begin
            winner = 1'b0;
            grant  = 2'b01;
        end else if (valid[1]) begin
            winner = 1'b1;
            grant  = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between execute (port 0) and address/branch (port 1), round-robin.
// Latency: accept at edge N gives a one-cycle response pulse at edge N+ALU_LAT+1.
// Backpressure: ready only while idle; responses are unthrottled single-cycle pulses.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int OPW     = ALU_OPW,
    parameter int ALU_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             grant_id
);

    logic       state;
    logic [2:0] cnt;
    logic       last_grant;
    logic [1:0] grant;
    logic       winner;
    logic       accept;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (winner)
    );

    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_op     <= winner ? req1_op : req0_op;
                        alu_a      <= winner ? req1_a  : req0_a;
                        alu_b      <= winner ? req1_b  : req0_b;
                        grant_id   <= winner;
                        last_grant <= winner;
                        busy       <= 1'b1;
                        cnt        <= 3'(ALU_LAT);
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // cnt reaching zero means the ALU result register now reflects our operands.
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        if (grant_id) begin
                            rsp1_valid <= 1'b1;
                            rsp1_data  <= alu_result;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_data  <= alu_result;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, hand sequences and random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        req0_valid, req0_ready, rsp0_valid;
    logic [2:0]  req0_op;
    logic [31:0] req0_a, req0_b, rsp0_data;
    logic        req1_valid, req1_ready, rsp1_valid;
    logic [2:0]  req1_op;
    logic [31:0] req1_a, req1_b, rsp1_data;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        busy, grant_id;

    logic        t3_req0_valid, t3_req0_ready, t3_rsp0_valid;
    logic [2:0]  t3_req0_op;
    logic [31:0] t3_req0_a, t3_req0_b, t3_rsp0_data;
    logic        t3_req1_valid, t3_req1_ready, t3_rsp1_valid;
    logic [2:0]  t3_req1_op;
    logic [31:0] t3_req1_a, t3_req1_b, t3_rsp1_data;
    logic [2:0]  t3_alu_op;
    logic [31:0] t3_alu_a, t3_alu_b, t3_alu_result;
    logic        t3_busy, t3_grant_id;

    alu_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .busy(busy), .grant_id(grant_id)
    );

    alu_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(3)) dut3 (
        .clock(clock), .reset(reset),
        .req0_valid(t3_req0_valid), .req0_ready(t3_req0_ready), .req0_op(t3_req0_op),
        .req0_a(t3_req0_a), .req0_b(t3_req0_b), .rsp0_valid(t3_rsp0_valid), .rsp0_data(t3_rsp0_data),
        .req1_valid(t3_req1_valid), .req1_ready(t3_req1_ready), .req1_op(t3_req1_op),
        .req1_a(t3_req1_a), .req1_b(t3_req1_b), .rsp1_valid(t3_rsp1_valid), .rsp1_data(t3_rsp1_data),
        .alu_op(t3_alu_op), .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_result(t3_alu_result),
        .busy(t3_busy), .grant_id(t3_grant_id)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Behavioural ALUs: result register(s) fed from the arbiter's drive.
    logic [31:0] alu1_q;
    always @(posedge clock) alu1_q <= alu_f(alu_op, alu_a, alu_b);
    assign alu_result = alu1_q;

    logic [31:0] alu3_q [3];
    always @(posedge clock) begin
        alu3_q[0] <= alu_f(t3_alu_op, t3_alu_a, t3_alu_b);
        alu3_q[1] <= alu3_q[0];
        alu3_q[2] <= alu3_q[1];
    end
    assign t3_alu_result = alu3_q[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: whether an op is outstanding and how many edges remain.
    bit          m_busy, m_last, m_gid, m_p0, m_p1;
    int          m_left;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_d0, m_d1;
    int          cyc = 0;
    bit          acc0, acc1, seen0, seen1;
    logic [31:0] got0, got1;
    int          acc0_edge, acc1_edge, lat0, lat1;

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_gid = 0; m_p0 = 0; m_p1 = 0; m_left = 0;
        m_op = '0; m_a = '0; m_b = '0; m_d0 = '0; m_d1 = '0;
        acc0 = 0; acc1 = 0;
    endtask

    task automatic step();
        bit e0, e1;
        @(negedge clock);
        e0 = 0; e1 = 0;
        if (!m_busy) begin
            if (req0_valid && req1_valid) begin
                if (m_last) e0 = 1; else e1 = 1;
            end else if (req0_valid) e0 = 1;
            else if (req1_valid) e1 = 1;
        end
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("busy", busy, m_busy);
        check("grant_id", grant_id, m_gid);
        check("rsp0_valid", rsp0_valid, m_p0);
        check("rsp1_valid", rsp1_valid, m_p1);
        check("rsp0_data", rsp0_data, m_d0);
        check("rsp1_data", rsp1_data, m_d1);
        check("alu_op", alu_op, m_op);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        if (rsp0_valid === 1'b1) begin seen0 = 1; got0 = rsp0_data; lat0 = cyc - 1 - acc0_edge; end
        if (rsp1_valid === 1'b1) begin seen1 = 1; got1 = rsp1_data; lat1 = cyc - 1 - acc1_edge; end
        @(posedge clock);
        acc0 = e0; acc1 = e1;
        m_p0 = 0; m_p1 = 0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                if (m_gid) begin m_p1 = 1; m_d1 = alu_f(m_op, m_a, m_b); end
                else       begin m_p0 = 1; m_d0 = alu_f(m_op, m_a, m_b); end
            end
        end else if (e0 || e1) begin
            m_busy = 1; m_left = 2; m_gid = e1; m_last = e1;
            m_op = e1 ? req1_op : req0_op;
            m_a  = e1 ? req1_a  : req0_a;
            m_b  = e1 ? req1_b  : req0_b;
            if (e0) acc0_edge = cyc; else acc1_edge = cyc;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_wait();
        int k = 0;
        while ((m_busy || m_p0 || m_p1) && k < 20) begin step(); k++; end
        check("idle_wait_timeout", k, (k < 20) ? k : 0);
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        model_reset();
    endtask

    typedef struct {
        logic        v0; logic [2:0] op0; logic [31:0] a0, b0;
        logic        v1; logic [2:0] op1; logic [31:0] a1, b1;
        logic [31:0] exp0, exp1;
        int          first;
    } vec_t;

    vec_t vt [7];

    task automatic run_vec(input vec_t v);
        int first = -1;
        int k = 0;
        seen0 = 0; seen1 = 0;
        req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
        while (k < 16 && !((seen0 || !v.v0) && (seen1 || !v.v1))) begin
            step();
            if (acc0) begin req0_valid = 0; if (first < 0) first = 0; end
            if (acc1) begin req1_valid = 0; if (first < 0) first = 1; end
            k++;
        end
        if (v.v0) begin
            check("vec_rsp0_seen", seen0, 1);
            check("vec_rsp0_data", got0, v.exp0);
            check("vec_rsp0_lat", lat0, 2);
        end
        if (v.v1) begin
            check("vec_rsp1_seen", seen1, 1);
            check("vec_rsp1_data", got1, v.exp1);
            check("vec_rsp1_lat", lat1, 2);
        end
        if (v.v0 && v.v1) check("vec_first", first, v.first);
        idle_wait();
    endtask

    int exp_rr [6];

    initial begin
        vt[0] = '{1, ALU_ADD, 32'd2,        32'd5, 1, ALU_SUB, 32'd10,       32'd3, 32'd7,        32'd7,  0};
        vt[1] = '{1, ALU_AND, 32'hF0,       32'h3C, 0, ALU_ADD, 32'd0,       32'd0, 32'h30,       32'd0,  0};
        vt[2] = '{0, ALU_ADD, 32'd0,        32'd0, 1, ALU_OR,  32'hF0,       32'h0F, 32'd0,       32'hFF, 0};
        vt[3] = '{1, ALU_XOR, 32'hFF,       32'h0F, 1, ALU_SLL, 32'd1,       32'd4, 32'hF0,       32'h10, 0};
        vt[4] = '{1, ALU_SRL, 32'h100,      32'd4, 1, ALU_SLT, 32'hFFFFFFFF, 32'd5, 32'h10,       32'd1,  0};
        vt[5] = '{1, ALU_SLT, 32'd5, 32'hFFFFFFFF, 0, ALU_ADD, 32'd0,       32'd0, 32'd0,        32'd0,  0};
        vt[6] = '{1, ALU_SUB, 32'd0,        32'd1, 1, ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0,  1};
        exp_rr = '{0, 1, 0, 1, 0, 1};

        reset = 1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        t3_req0_valid = 0; t3_req0_op = 0; t3_req0_a = 0; t3_req0_b = 0;
        t3_req1_valid = 0; t3_req1_op = 0; t3_req1_a = 0; t3_req1_b = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_data", rsp0_data, 0);
        check("rst_rsp1_data", rsp1_data, 0);
        reset = 0;

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Continuous contention after reset: strict alternation, one accept per three cycles.
        begin
            int nacc = 0;
            int prev = -1;
            int k = 0;
            do_reset();
            req0_valid = 1; req0_op = 3'($urandom_range(0, 7)); req0_a = $urandom; req0_b = $urandom;
            req1_valid = 1; req1_op = 3'($urandom_range(0, 7)); req1_a = $urandom; req1_b = $urandom;
            while (nacc < 6 && k < 40) begin
                step();
                if (acc0 || acc1) begin
                    check("rr_grant", acc1, exp_rr[nacc]);
                    check("rr_grant_id", grant_id, exp_rr[nacc]);
                    if (prev >= 0) check("rr_spacing", cyc - 1 - prev, 3);
                    prev = cyc - 1;
                    nacc++;
                    if (acc0) begin req0_op = 3'($urandom_range(0, 7)); req0_a = $urandom; req0_b = $urandom; end
                    else      begin req1_op = 3'($urandom_range(0, 7)); req1_a = $urandom; req1_b = $urandom; end
                end
                k++;
            end
            check("rr_count", nacc, 6);
            req0_valid = 0; req1_valid = 0;
            idle_wait();
        end

        // Operand change while busy must not reach the ALU or the result.
        begin
            int k = 0;
            seen0 = 0;
            req0_valid = 1; req0_op = ALU_ADD; req0_a = 32'd2; req0_b = 32'd5;
            step();
            check("t4_accept", acc0, 1);
            req0_valid = 0; req0_a = 32'd9;
            step();
            check("t4_alu_a_held", alu_a, 32'd2);
            while (!seen0 && k < 10) begin step(); k++; end
            check("t4_result", got0, 32'd7);
            seen0 = 0; k = 0;
            req0_valid = 1;
            while (!seen0 && k < 10) begin step(); if (acc0) req0_valid = 0; k++; end
            check("t4_next_result", got0, 32'd14);
        end

        // Reset one cycle after an accept: immediate abort, no pulse, then normal service.
        begin
            int k = 0;
            idle_wait();
            req0_valid = 1; req0_op = ALU_ADD; req0_a = 32'd2; req0_b = 32'd5;
            step();
            check("t5_accept", acc0, 1);
            req0_valid = 0;
            step();
            reset = 1;
            #1;
            check("t5_busy", busy, 0);
            check("t5_alu_op", alu_op, 0);
            check("t5_alu_a", alu_a, 0);
            check("t5_alu_b", alu_b, 0);
            check("t5_rsp0_valid", rsp0_valid, 0);
            check("t5_rsp0_data", rsp0_data, 0);
            repeat (3) begin
                @(negedge clock);
                check("t5_no_pulse", rsp0_valid | rsp1_valid, 0);
            end
            @(posedge clock); #1;
            reset = 0;
            model_reset();
            seen0 = 0;
            req0_valid = 1; req0_op = ALU_ADD; req0_a = 32'd3; req0_b = 32'd4;
            while (!seen0 && k < 10) begin step(); if (acc0) req0_valid = 0; k++; end
            check("t5_post_reset_result", got0, 32'd7);
            idle_wait();
        end

        // Random two-port traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            step();
            if (acc0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op = 3'($urandom_range(0, 7)); req0_a = $urandom;
                req0_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            end
            if (acc1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op = 3'($urandom_range(0, 7)); req1_a = $urandom;
                req1_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            end
        end
        begin
            int k = 0;
            while ((req0_valid || req1_valid) && k < 20) begin
                step();
                if (acc0) req0_valid = 0;
                if (acc1) req1_valid = 0;
                k++;
            end
            check("rand_drain", req0_valid | req1_valid, 0);
            idle_wait();
        end

        // Three-stage ALU instance: AND 0xF0,0x3C answers four edges after accept.
        begin
            int busy_n = 0;
            int pulse_edge = -1;
            int npulse = 0;
            logic [31:0] d = '0;
            t3_req0_valid = 1; t3_req0_op = ALU_AND; t3_req0_a = 32'hF0; t3_req0_b = 32'h3C;
            @(negedge clock);
            check("t6_ready", t3_req0_ready, 1);
            @(posedge clock); #1;
            t3_req0_valid = 0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clock);
                if (t3_busy) busy_n++;
                if (t3_rsp0_valid) begin pulse_edge = k - 1; npulse++; d = t3_rsp0_data; end
                check("t6_no_rsp1", t3_rsp1_valid, 0);
            end
            check("t6_busy_cycles", busy_n, 4);
            check("t6_pulse_edge", pulse_edge, 4);
            check("t6_pulse_count", npulse, 1);
            check("t6_data", d, 32'h30);
            check("t6_alu_a_held", t3_alu_a, 32'hF0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
